// File: rtl/mul_seq_if.sv
// rtl/mul_seq_if.sv - start/done request bundle between the execute stage and mul_seq
// The requester owns operands and start; the multiplier returns ready, done and the result word.
interface mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, op_i, a_i, b_i,
    input  ready_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i,
    output ready_o, done_o, result_o
  );
endinterface

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative shift-add multiplier, one multiplier bit per cycle, RV32M MUL/MULH/MULHSU/MULHU
// Operands are reduced to magnitudes at accept; the sign is restored on the 64-bit product in FIX.
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  mul_seq_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [1:0] OP_MUL = 2'b00;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH:0]     carry;
  logic               a_neg, b_neg;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // Bit WIDTH of the partial-product sum is the ripple carry out of the top cell.
  assign addend   = mq_q[0] ? mcand_q : '0;
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa u_fa (
      .a_i (acc_q[i]),
      .b_i (addend[i]),
      .c_i (carry[i]),
      .s_o (sum[i]),
      .c_o (carry[i+1])
    );
  end

  // a is signed for MUL/MULH/MULHSU, b only for MUL/MULH.
  assign a_neg    = (bus.op_i != 2'b11) && bus.a_i[WIDTH-1];
  assign b_neg    = !bus.op_i[1] && bus.b_i[WIDTH-1];
  assign prod     = {acc_q, mq_q};
  assign prod_fix = neg_q ? (~prod + 1'b1) : prod;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mq_d     = mq_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          op_d    = bus.op_i;
          mcand_d = a_neg ? (~bus.a_i + 1'b1) : bus.a_i;
          mq_d    = b_neg ? (~bus.b_i + 1'b1) : bus.b_i;
          neg_d   = a_neg ^ b_neg;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = {carry[WIDTH], sum[WIDTH-1:1]};
        mq_d  = {sum[0], mq_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = (op_q == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      mcand_q  <= '0;
      mq_q     <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mq_q     <= mq_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - directed vector table plus timing, busy and reset-abort sequences for mul_seq
module tb_mul_seq;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mul_seq_if #(.WIDTH(32)) bus ();

  mul_seq #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept at E0, then scramble the inputs and watch 36 further edges.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit busy, output logic [31:0] res,
                        output int done_edge, output int done_cnt);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    tick();
    bus.start_i = 1'b0;
    bus.op_i    = ~op;
    bus.a_i     = ~a ^ 32'h5a5a_0f0f;
    bus.b_i     = b + 32'd7;
    done_edge   = -1;
    done_cnt    = 0;
    res         = '0;
    for (int k = 1; k <= 36; k++) begin
      if (busy && (k == 5 || k == 20)) begin
        bus.start_i = 1'b1;
        bus.op_i    = 2'b11;
        bus.a_i     = 32'hdead_beef;
        bus.b_i     = 32'h0000_1234;
      end
      tick();
      bus.start_i = 1'b0;
      if (bus.done_o) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = k;
          res       = bus.result_o;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] res;
    int          de;
    int          dc;

    vecs[0] = '{"mul_3x5",        2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F};
    vecs[1] = '{"mulh_m1xm1",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2] = '{"mul_m1xm1",      2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[3] = '{"mulhu_m1xm1",    2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[4] = '{"mulhsu_m1xm1",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5] = '{"mulh_min_min",   2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[6] = '{"mul_min_m1",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[7] = '{"mulhu_x0",       2'b11, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{"mulh_m3x7",      2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[9] = '{"mul_m3x7",       2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB};

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.a_i     = '0;
    bus.b_i     = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ready",  32'(bus.ready_o),  32'd1);
    chk("reset_done",   32'(bus.done_o),   32'd0);
    chk("reset_result", bus.result_o,      32'd0);

    // Cycle-exact handshake for MUL 3 x 5.
    bus.start_i = 1'b1;
    bus.op_i    = 2'b00;
    bus.a_i     = 32'd3;
    bus.b_i     = 32'd5;
    tick();
    bus.start_i = 1'b0;
    chk("e0_ready_low", 32'(bus.ready_o), 32'd0);
    for (int k = 1; k <= 32; k++) tick();
    chk("e32_done_low",  32'(bus.done_o),  32'd0);
    chk("e32_ready_low", 32'(bus.ready_o), 32'd0);
    tick();
    chk("e33_done_high", 32'(bus.done_o), 32'd1);
    chk("e33_result",    bus.result_o,    32'h0000_000F);
    tick();
    chk("e34_done_low",   32'(bus.done_o),  32'd0);
    chk("e34_ready_high", 32'(bus.ready_o), 32'd1);
    chk("e34_result_held", bus.result_o,    32'h0000_000F);

    for (int i = 0; i < 10; i++) begin
      chk({vecs[i].name, "_ready"}, 32'(bus.ready_o), 32'd1);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, res, de, dc);
      chk({vecs[i].name, "_result"},    res,            vecs[i].exp);
      chk({vecs[i].name, "_done_edge"}, 32'(de),        32'd33);
      chk({vecs[i].name, "_done_cnt"},  32'(dc),        32'd1);
      chk({vecs[i].name, "_held"},      bus.result_o,   vecs[i].exp);
    end

    run_op(2'b00, 32'd7, 32'd9, 1'b1, res, de, dc);
    chk("busy_result",    res,     32'h0000_003F);
    chk("busy_done_edge", 32'(de), 32'd33);
    chk("busy_done_cnt",  32'(dc), 32'd1);

    // Abort mid-CALC with a nonzero previous result on the output.
    bus.start_i = 1'b1;
    bus.op_i    = 2'b11;
    bus.a_i     = 32'hFFFF_FFFF;
    bus.b_i     = 32'hFFFF_FFFF;
    tick();
    bus.start_i = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready",  32'(bus.ready_o), 32'd1);
    chk("abort_done",   32'(bus.done_o),  32'd0);
    chk("abort_result", bus.result_o,     32'd0);
    dc = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done_o) dc++;
    end
    chk("abort_no_done", 32'(dc), 32'd0);
    run_op(2'b11, 32'd2, 32'd3, 1'b0, res, de, dc);
    chk("after_abort_result",    res,     32'd0);
    chk("after_abort_done_edge", 32'(de), 32'd33);
    chk("after_abort_done_cnt",  32'(dc), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
